// File: rtl/wrn_fw_loader_if.sv
// wrn_fw_loader_if: valid/ready write-beat port (byte address + data word) feeding the firmware loader
interface wrn_fw_loader_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] data;
    modport master (output valid, addr, data, input ready);
    modport slave (input valid, addr, data, output ready);
endinterface

// File: rtl/wrn_fw_loader.sv
// wrn_fw_loader: streams beats into one core's IRAM, holding that core in reset during the load and releasing it on done
// Optional checksum_o output is enabled by defining WRN_FW_LOADER_CHECKSUM_EN.
module wrn_fw_loader #(
    parameter int g_num_cores   = 2,
    parameter int g_iram_size   = 16384,
    parameter int g_halt_cycles = 4,
    localparam int SW = (g_num_cores > 1) ? $clog2(g_num_cores) : 1,
    localparam int AW = $clog2(g_iram_size / 4)
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_n_i,
    input  logic [SW-1:0]          core_sel_i,
    input  logic                   start_i,
    input  logic                   done_i,
    input  logic                   abort_i,
    wrn_fw_loader_if.slave         wr,
    output logic [g_num_cores-1:0] iram_we_o,
    output logic [AW-1:0]          iram_addr_o,
    output logic [31:0]            iram_data_o,
    output logic [g_num_cores-1:0] core_reset_o,
    output logic [g_num_cores-1:0] core_enable_o,
    output logic                   busy_o,
    output logic                   err_o,
`ifdef WRN_FW_LOADER_CHECKSUM_EN
    output logic [31:0]            checksum_o,
`endif
    output logic [AW:0]            word_count_o
);
    typedef enum logic [1:0] {IDLE, HALT, LOAD, RELEASE} state_t;
    localparam int CW = $clog2(g_halt_cycles + 1);
    localparam logic [CW-1:0] HALT_LOAD = CW'(g_halt_cycles);
    localparam logic [SW:0] NUM_CORES = (SW + 1)'(g_num_cores);
    localparam logic [g_num_cores-1:0] ONE = g_num_cores'(1);
    state_t state, state_nxt;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;
    logic [g_num_cores-1:0] sel_mask, start_mask;
    logic sel_ok, legal, start_ok, start_bad, write, beat_bad, release_core;
    assign sel_ok     = {1'b0, core_sel_i} < NUM_CORES;
    assign legal      = (wr.addr[1:0] == 2'b00) && (wr.addr < 32'(g_iram_size));
    assign sel_mask   = ONE << sel;
    assign start_mask = ONE << core_sel_i;
    assign busy_o     = state != IDLE;
    // Next-state and per-cycle control decode; abort beats done, and a beat aborted in flight is dropped silently
    always_comb begin
        state_nxt    = state;
        wr.ready     = 1'b0;
        start_ok     = 1'b0;
        start_bad    = 1'b0;
        write        = 1'b0;
        beat_bad     = 1'b0;
        release_core = 1'b0;
        case (state)
            IDLE: begin
                start_ok  = start_i && sel_ok;
                start_bad = start_i && !sel_ok;
                state_nxt = start_ok ? HALT : IDLE;
            end
            HALT: state_nxt = abort_i ? IDLE : (cnt == CW'(1)) ? LOAD : HALT;
            LOAD: begin
                wr.ready  = 1'b1;
                write     = wr.valid && legal && !abort_i;
                beat_bad  = wr.valid && !legal && !abort_i;
                state_nxt = abort_i ? IDLE : done_i ? RELEASE : LOAD;
            end
            RELEASE: begin
                release_core = 1'b1;
                state_nxt    = IDLE;
            end
        endcase
    end
    // Session state register
    always_ff @(posedge clk_sys_i or negedge rst_n_i)
        if (!rst_n_i) state <= IDLE;
        else state <= state_nxt;
    // Registered IRAM write port, session bookkeeping and per-core reset/enable sequencing
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel           <= '0;
            cnt           <= '0;
            iram_we_o     <= '0;
            iram_addr_o   <= '0;
            iram_data_o   <= '0;
            core_reset_o  <= '1;
            core_enable_o <= '0;
            err_o         <= 1'b0;
            word_count_o  <= '0;
`ifdef WRN_FW_LOADER_CHECKSUM_EN
            checksum_o    <= '0;
`endif
        end else begin
            iram_we_o <= write ? sel_mask : '0;
            if (write) begin
                iram_addr_o <= wr.addr[AW+1:2];
                iram_data_o <= wr.data;
                if (!word_count_o[AW]) word_count_o <= word_count_o + (AW + 1)'(1);
`ifdef WRN_FW_LOADER_CHECKSUM_EN
                checksum_o <= checksum_o + wr.data;
`endif
            end
            if (beat_bad || start_bad) err_o <= 1'b1;
            if (state == HALT) cnt <= cnt - CW'(1);
            if (start_ok) begin
                sel           <= core_sel_i;
                cnt           <= HALT_LOAD;
                err_o         <= 1'b0;
                word_count_o  <= '0;
                core_reset_o  <= core_reset_o | start_mask;
                core_enable_o <= core_enable_o & ~start_mask;
`ifdef WRN_FW_LOADER_CHECKSUM_EN
                checksum_o    <= '0;
`endif
            end
            if (release_core) begin
                core_reset_o  <= core_reset_o & ~sel_mask;
                core_enable_o <= core_enable_o | sel_mask;
            end
        end
    end
endmodule

// File: tb/tb_wrn_fw_loader.sv
// tb_wrn_fw_loader: table vectors, corner sequences and random sessions against a transaction-level loader model
module tb_wrn_fw_loader;
    localparam int NC   = 3;
    localparam int IS   = 16384;
    localparam int HC   = 4;
    localparam int AW   = 12;
    localparam int WMAX = 4096;
    typedef enum {P_IDLE, P_HALT, P_LOAD, P_REL} phase_t;
    typedef struct {
        logic        start;
        logic [1:0]  sel;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        abort;
        logic        busy;
        logic        err;
        logic [AW:0] wc;
    } vec_t;
    typedef struct {
        logic [NC-1:0] we;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk_sys_i = 1'b0;
    logic          rst_n_i   = 1'b0;
    logic [1:0]    core_sel_i = 2'd0;
    logic          start_i = 1'b0, done_i = 1'b0, abort_i = 1'b0;
    logic [NC-1:0] iram_we_o, core_reset_o, core_enable_o;
    logic [AW-1:0] iram_addr_o;
    logic [31:0]   iram_data_o;
    logic          busy_o, err_o;
    logic [AW:0]   word_count_o;
`ifdef WRN_FW_LOADER_CHECKSUM_EN
    logic [31:0]   checksum_o;
`endif
    wrn_fw_loader_if wr();

    wrn_fw_loader #(.g_num_cores(NC), .g_iram_size(IS), .g_halt_cycles(HC)) dut (
        .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i), .core_sel_i(core_sel_i),
        .start_i(start_i), .done_i(done_i), .abort_i(abort_i), .wr(wr),
        .iram_we_o(iram_we_o), .iram_addr_o(iram_addr_o), .iram_data_o(iram_data_o),
        .core_reset_o(core_reset_o), .core_enable_o(core_enable_o),
        .busy_o(busy_o), .err_o(err_o),
`ifdef WRN_FW_LOADER_CHECKSUM_EN
        .checksum_o(checksum_o),
`endif
        .word_count_o(word_count_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    int            n_vec = 0, n_bad = 0;
    wr_t           exp_q[$];
    phase_t        ph = P_IDLE;
    logic [1:0]    sel_m = 2'd0;
    int            wc_m = 0;
    logic          err_m = 1'b0;
    logic [31:0]   sum_m = 32'h0;
    logic [NC-1:0] rst_m = '1, en_m = '0;
    vec_t          tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys_i);
        #1;
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < IS);
    endfunction

    // every IRAM strobe must match the next write the model predicted, one cycle per write
    always @(negedge clk_sys_i) begin
        wr_t w;
        if (iram_we_o != '0) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: we=%b addr=%0h data=%0h, required no write", iram_we_o, iram_addr_o, iram_data_o);
            end else begin
                w = exp_q.pop_front();
                chk("iram_we", iram_we_o, w.we);
                chk("iram_addr", iram_addr_o, w.a);
                chk("iram_data", iram_data_o, w.d);
            end
        end
    end

    task automatic apply(input vec_t v);
        wr_t w;
        core_sel_i = v.sel;
        start_i    = v.start;
        wr.valid   = v.valid;
        wr.addr    = v.addr;
        wr.data    = v.data;
        done_i     = v.done;
        abort_i    = v.abort;
        if (ph == P_IDLE) begin
            if (v.start && v.sel < NC) begin
                sel_m = v.sel;
                wc_m  = 0;
                err_m = 1'b0;
                sum_m = 32'h0;
                rst_m[v.sel] = 1'b1;
                en_m[v.sel]  = 1'b0;
                ph = P_HALT;
            end else if (v.start) err_m = 1'b1;
        end else if (ph == P_LOAD) begin
            if (v.valid && !v.abort) begin
                if (legal(v.addr)) begin
                    w.we = '0;
                    w.we[sel_m] = 1'b1;
                    w.a = AW'(v.addr / 4);
                    w.d = v.data;
                    exp_q.push_back(w);
                    wc_m = (wc_m < WMAX) ? wc_m + 1 : WMAX;
                    sum_m += v.data;
                end else err_m = 1'b1;
            end
            if (v.abort) ph = P_IDLE;
            else if (v.done) ph = P_REL;
        end
        cyc();
        start_i  = 1'b0;
        wr.valid = 1'b0;
        done_i   = 1'b0;
        abort_i  = 1'b0;
    endtask

    task automatic post();
        int k = 0;
        if (ph == P_HALT) begin
            chk("drained", exp_q.size(), 0);
            chk("busy_rise", busy_o, 1'b1);
            while (!wr.ready && k < 4 * HC + 8) begin
                cyc();
                k++;
            end
            chk("halt_len", k, HC);
            ph = P_LOAD;
        end else if (ph == P_REL) begin
            chk("rel_reset_held", core_reset_o[sel_m], 1'b1);
            chk("rel_busy", busy_o, 1'b1);
            cyc();
            rst_m[sel_m] = 1'b0;
            en_m[sel_m]  = 1'b1;
            ph = P_IDLE;
        end
    endtask

    task automatic check_model();
        chk("busy", busy_o, ph != P_IDLE);
        chk("ready", wr.ready, ph == P_LOAD);
        chk("err", err_o, err_m);
        chk("word_count", word_count_o, wc_m);
`ifdef WRN_FW_LOADER_CHECKSUM_EN
        chk("checksum", checksum_o, sum_m);
`endif
        chk("core_reset", core_reset_o, rst_m);
        chk("core_enable", core_enable_o, en_m);
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0: return ($urandom_range(0, IS / 4 - 1) * 4) + $urandom_range(1, 3);
            1: return IS + $urandom_range(0, 4 * IS);
            2: return $urandom() | 32'h8000_0000;
            default: return $urandom_range(0, IS / 4 - 1) * 4;
        endcase
    endfunction

    function automatic vec_t rnd_row(input logic fin);
        vec_t v;
        v = '{default: '0};
        v.valid = $urandom_range(0, 3) != 0;
        v.addr  = rnd_addr();
        v.data  = $urandom();
        v.start = $urandom_range(0, 7) == 0;
        v.sel   = 2'($urandom_range(0, 3));
        if (fin) begin
            case ($urandom_range(0, 2))
                0: v.done = 1'b1;
                1: v.abort = 1'b1;
                default: begin
                    v.done  = 1'b1;
                    v.abort = 1'b1;
                end
            endcase
        end
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int nb;
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 13'd0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h0,    32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 13'd1};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h4,    32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 13'd2};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h8,    32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 13'd3};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h0,    32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 13'd3};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 13'd0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h6,    32'hdeadbeef, 1'b0, 1'b0, 1'b1, 1'b1, 13'd0};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h4000, 32'hcafef00d, 1'b0, 1'b0, 1'b1, 1'b1, 13'd0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h10,   32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, 13'd1};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 32'h3ffc, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b1, 13'd2};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 32'h20,   32'h66666666, 1'b0, 1'b1, 1'b0, 1'b1, 13'd2};
        tbl[11] = '{1'b1, 2'd3, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 13'd2};
        tbl[12] = '{1'b1, 2'd0, 1'b0, 32'h0,    32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 13'd0};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 32'h100,  32'h0000aaaa, 1'b0, 1'b0, 1'b1, 1'b0, 13'd1};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 32'h104,  32'h0000bbbb, 1'b1, 1'b0, 1'b1, 1'b0, 13'd2};
        wr.valid = 1'b0;
        wr.addr  = 32'h0;
        wr.data  = 32'h0;
        repeat (3) cyc();
        chk("rst_core_reset_in_reset", core_reset_o, 3'b111);
        rst_n_i = 1'b1;
        repeat (10) cyc();
        chk("rst_core_reset", core_reset_o, 3'b111);
        chk("rst_core_enable", core_enable_o, 3'b000);
        chk("rst_ready", wr.ready, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_word_count", word_count_o, 13'd0);
        chk("rst_iram_we", iram_we_o, 3'b000);
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i]);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("tbl%0d_err", i), err_o, tbl[i].err);
            chk($sformatf("tbl%0d_word_count", i), word_count_o, tbl[i].wc);
`ifdef WRN_FW_LOADER_CHECKSUM_EN
            if (i == 4) chk("tbl_checksum", checksum_o, 32'h66666666);
`endif
            post();
            check_model();
        end
        v = '{default: '0};
        v.start = 1'b1;
        v.sel   = 2'd2;
        apply(v);
        post();
        for (int i = 0; i <= WMAX; i++) begin
            v = '{default: '0};
            v.valid = 1'b1;
            v.addr  = 32'((i % WMAX) * 4);
            v.data  = $urandom();
            v.done  = (i == WMAX);
            apply(v);
        end
        chk("wc_saturate", word_count_o, 13'd4096);
        post();
        check_model();
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                v = rnd_row(1'b1);
                v.start = 1'b0;
                apply(v);
                check_model();
            end
            v = '{default: '0};
            v.start = 1'b1;
            v.sel   = 2'($urandom_range(0, 3));
            apply(v);
            post();
            check_model();
            if (ph == P_LOAD) begin
                nb = $urandom_range(0, 10);
                for (int b = 0; b < nb; b++) begin
                    apply(rnd_row(1'b0));
                    check_model();
                end
                apply(rnd_row(1'b1));
                post();
                check_model();
            end
        end
        v = '{default: '0};
        v.start = 1'b1;
        v.sel   = 2'd2;
        apply(v);
        post();
        for (int i = 0; i < 5; i++) begin
            v = '{default: '0};
            v.valid = 1'b1;
            v.addr  = 32'(i * 4 + 64);
            v.data  = $urandom();
            apply(v);
        end
        #2 rst_n_i = 1'b0;
        #1;
        chk("arst_core_reset", core_reset_o, 3'b111);
        chk("arst_core_enable", core_enable_o, 3'b000);
        chk("arst_ready", wr.ready, 1'b0);
        chk("arst_iram_we", iram_we_o, 3'b000);
        chk("arst_iram_addr", iram_addr_o, 12'h0);
        chk("arst_iram_data", iram_data_o, 32'h0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_err", err_o, 1'b0);
        chk("arst_word_count", word_count_o, 13'd0);
`ifdef WRN_FW_LOADER_CHECKSUM_EN
        chk("arst_checksum", checksum_o, 32'h0);
`endif
        exp_q.delete();
        ph    = P_IDLE;
        rst_m = '1;
        en_m  = '0;
        wc_m  = 0;
        err_m = 1'b0;
        sum_m = 32'h0;
        @(negedge clk_sys_i);
        rst_n_i = 1'b1;
        repeat (3) cyc();
        check_model();
        chk("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
